// File: rtl/uart_tx_8n1.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, optional parity, one stop.
// The line register and the FSM change on the same edge, so o_uart_tx tracks state exactly.
module uart_tx_8n1 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       i_clk_sys,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_uart_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_parity
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end    = (cnt == CNT_LAST);
  assign o_tx_ready = (state == S_IDLE) && !i_rst;
  assign o_tx_busy  = (state != S_IDLE);
  assign o_tx_done  = (state == S_STOP) && bit_end;

  // Bit-period counter: held at zero in IDLE, restarts on every bit boundary.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst)                           cnt <= '0;
    else if (state == S_IDLE || bit_end) cnt <= '0;
    else                                 cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      shift     <= '0;
      o_uart_tx <= 1'b1;
      o_parity  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_uart_tx <= 1'b1;
          if (i_tx_valid && o_tx_ready) begin
            shift     <= i_tx_data;
            o_parity  <= ^i_tx_data ^ ODD;
            o_uart_tx <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: if (bit_end) begin
          o_uart_tx <= shift[0];
          state     <= S_DATA;
        end
        S_DATA: if (bit_end) begin
          shift <= shift >> 1;
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
            o_uart_tx <= HAS_PAR ? o_parity : 1'b1;
            state     <= HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            o_uart_tx <= shift[1];
          end
        end
        S_PARITY: if (bit_end) begin
          o_uart_tx <= 1'b1;
          state     <= S_STOP;
        end
        S_STOP: if (bit_end) begin
          o_uart_tx <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          o_uart_tx <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: three instances (no parity, even, odd) checked every cycle
// against a frame-level model, plus literal frame/timing expectations.
module tb_uart_tx_8n1;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 16;
  localparam bit PE [3] = '{1'b0, 1'b1, 1'b1};
  localparam bit PO [3] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data;
  logic [2:0] valid;
  logic [2:0] ready, line, busy, done, par;

  uart_tx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .i_clk_sys(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid[0]),
    .o_tx_ready(ready[0]), .o_uart_tx(line[0]), .o_tx_busy(busy[0]),
    .o_tx_done(done[0]), .o_parity(par[0]));
  uart_tx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .i_clk_sys(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid[1]),
    .o_tx_ready(ready[1]), .o_uart_tx(line[1]), .o_tx_busy(busy[1]),
    .o_tx_done(done[1]), .o_parity(par[1]));
  uart_tx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .i_clk_sys(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid[2]),
    .o_tx_ready(ready[2]), .o_uart_tx(line[2]), .o_tx_busy(busy[2]),
    .o_tx_done(done[2]), .o_parity(par[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Frame model: a frame is a list of line levels, each held CPB cycles from the accept edge.
  bit         m_busy [3];
  int         m_k    [3];
  int         m_n    [3];
  logic [10:0] m_bits [3];
  logic       m_par  [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0; m_k[i] = 0; m_par[i] = 1'b0;
      end else if (m_busy[i]) begin
        if (m_k[i] == m_n[i] * CPB - 1) m_busy[i] = 1'b0;
        else m_k[i]++;
      end else if (valid[i]) begin
        m_par[i]  = ^data ^ PO[i];
        m_bits[i] = PE[i] ? {1'b1, m_par[i], data, 1'b0} : {2'b11, data, 1'b0};
        m_n[i]    = PE[i] ? 11 : 10;
        m_busy[i] = 1'b1;
        m_k[i]    = 0;
      end
    end
  end

  logic el;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      el = m_busy[i] ? m_bits[i][m_k[i] / CPB] : 1'b1;
      chk("line",   i, 32'(line[i]),  32'(el));
      chk("busy",   i, 32'(busy[i]),  32'(m_busy[i]));
      chk("done",   i, 32'(done[i]),  32'(m_busy[i] && m_k[i] == m_n[i] * CPB - 1));
      chk("ready",  i, 32'(ready[i]), 32'(!m_busy[i] && !rst));
      chk("parity", i, 32'(par[i]),   32'(m_par[i]));
    end
  end

  task automatic wait_ready(input int i);
    int n = 0;
    while (!ready[i] && n < 2000) begin @(negedge clk); n++; end
    chk("ready_wait", i, 32'(ready[i]), 32'd1);
  endtask

  // Sends one byte, samples the line at bit centres and records the done cycle.
  task automatic run_frame(input int i, input logic [7:0] b, input bit poke, input int rst_at,
                           output logic [10:0] v, output int td);
    v = '1; td = -1;
    wait_ready(i);
    data = b; valid[i] = 1'b1;
    @(posedge clk); #2 valid[i] = 1'b0;
    for (int t = 0; t < 12 * CPB; t++) begin
      @(negedge clk);
      if (t % CPB == CPB / 2 && t / CPB < 11) v[t / CPB] = line[i];
      if (done[i] && td < 0) td = t;
      if (poke && t == 3 * CPB) begin data = 8'h00; valid[i] = 1'b1; end
      if (poke && t == 3 * CPB + 1) valid[i] = 1'b0;
      if (rst_at > 0 && t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_line", i, 32'(line[i]), 32'd1);
        chk("rst_busy", i, 32'(busy[i]), 32'd0);
        chk("rst_ready", i, 32'(ready[i]), 32'd0);
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", i, 32'(ready[i]), 32'd1);
        break;
      end
    end
  endtask

  logic [10:0] v;
  int td, tf;
  logic prev;

  initial begin
    rst = 1'b1; valid = '0; data = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 0, 32'(ready), 32'd0);
    chk("reset_line",  0, 32'(line),  32'h7);
    chk("reset_busy",  0, 32'(busy),  32'd0);
    chk("reset_par",   0, 32'(par),   32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("release_ready", 0, 32'(ready), 32'h7);

    run_frame(0, 8'hAC, 1'b0, 0, v, td);
    chk("frame_ac", 0, 32'(v[9:0]), 32'(10'b1_1010_1100_0));
    chk("done_cyc", 0, 32'(td), 32'(10 * CPB - 1));
    chk("par_ac",   0, 32'(par[0]), 32'd0);

    run_frame(1, 8'hAC, 1'b0, 0, v, td);
    chk("frame_even_ac", 1, 32'(v), 32'(11'b10_1010_1100_0));
    chk("done_cyc_par",  1, 32'(td), 32'(11 * CPB - 1));

    run_frame(2, 8'h07, 1'b0, 0, v, td);
    chk("odd_07_bit", 2, 32'(v[9]), 32'd0);
    chk("odd_07_par", 2, 32'(par[2]), 32'd0);
    run_frame(2, 8'hAC, 1'b0, 0, v, td);
    chk("odd_ac_bit", 2, 32'(v[9]), 32'd1);
    chk("odd_ac_par", 2, 32'(par[2]), 32'd1);

    run_frame(0, 8'hAC, 1'b1, 0, v, td);
    chk("ignored_frame", 0, 32'(v[9:0]), 32'(10'b1_1010_1100_0));
    chk("no_refire", 0, 32'(busy[0]), 32'd0);

    run_frame(0, 8'hAC, 1'b0, 4 * CPB, v, td);
    chk("rst_no_done", 0, 32'(td), 32'hFFFF_FFFF);

    // Back-to-back: valid held across the first frame's end.
    wait_ready(0);
    data = 8'h55; valid[0] = 1'b1;
    @(posedge clk); #2 data = 8'hFF;
    tf = -1; prev = 1'b0;
    for (int t = 0; t < 22 * CPB; t++) begin
      @(negedge clk);
      if (tf < 0 && t > 9 * CPB && prev && !line[0]) begin tf = t; valid[0] = 1'b0; end
      prev = line[0];
    end
    chk("b2b_gap", 0, 32'(tf), 32'(10 * CPB + 1));

    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) valid[i] = ($urandom_range(0, 2) != 0);
      data = 8'($urandom);
      rst  = ($urandom_range(0, 1999) == 0);
    end
    #2 valid = '0; rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("final_idle", 0, 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_8n1.md
# uart_tx_8n1

UART transmitter that serialises one byte per valid/ready handshake onto `o_uart_tx`: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It is the transmit counterpart to the UART receive path feeding `uart_loop`. It drives the board TX pin and is the loopback source for receiver benches. Baud timing is derived from the system clock by an internal bit-period counter.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency, Hz.
- `BAUD`, 9600: line rate.
  - CLKS_PER_BIT = CLK_FREQ / BAUD, integer division; 5208 at the defaults.
  - 5208 cycles at 20 ns = 104160 ns per bit.
- `PARITY_EN`, 0: 1 inserts a parity bit between the data bits and the stop bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN = 0.
- `i_clk_sys`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_tx_data`  in  8  byte to send; sampled only on the accept edge.
- `i_tx_valid`  in  1  byte request.
- `o_tx_ready`  out  1  block can accept a byte.
- `o_uart_tx`  out  1  serial line, registered, idles high.
- `o_tx_busy`  out  1  high while a frame is on the line.
- `o_tx_done`  out  1  one-cycle pulse in the last cycle of the stop bit.
- `o_parity`  out  1  computed parity of the last accepted byte, registered; valid even when PARITY_EN = 0.

## Operation
- Reset is asynchronous, active-high: one clock; asynchronous assertion, release on the next clock edge.
- Reset values:
  - state = IDLE; `o_uart_tx` = 1; `o_tx_busy` = 0; `o_tx_done` = 0; `o_parity` = 0.
  - Bit counter = 0; index = 0; shift register = 0.
  - `o_tx_ready` = 0 while `i_rst` is high.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - `o_tx_ready` = 1 (combinational, from state == IDLE and !i_rst); `o_uart_tx` = 1.
  - Accept = `i_tx_valid` && `o_tx_ready`.
  - On accept: load the shift register with `i_tx_data`; load `o_parity` with ^i_tx_data ^ PARITY_ODD; go to START.
- START: line 0 for CLKS_PER_BIT cycles.
- DATA:
  - Line = shift[0] for CLKS_PER_BIT cycles, then shift right.
  - Eight bits, tracked by a 3-bit index; index wraps from 7 to 0 on exit.
- PARITY: line = `o_parity` for CLKS_PER_BIT cycles.
- STOP:
  - Line 1 for CLKS_PER_BIT cycles.
  - `o_tx_done` = 1 in the final cycle; then go to IDLE.
- Bit counter:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Resets to 0 on every state or bit change.
  - Never free-runs in IDLE.
- `o_tx_busy` = 1 in every state except IDLE.
- `i_tx_valid` and `i_tx_data` are ignored outside IDLE. There is no queueing; the requester must hold `i_tx_valid` until it sees ready.
- Changes to `i_tx_data` after the accept edge do not affect the frame in flight.
- Reset mid-frame: the line returns to 1 immediately (asynchronously); the frame is truncated; no `o_tx_done` pulse.

## Timing
- Accept at edge N: `o_uart_tx` falls at edge N+1 (registered output).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length from start-bit fall to stop-bit end: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- `o_tx_done` is high during the last STOP cycle; IDLE and `o_tx_ready` = 1 follow on the next cycle.
- Back-to-back with `i_tx_valid` held high:
  - Next accept in the first IDLE cycle.
  - Next start bit begins 1 cycle later.
  - Effective stop time = CLKS_PER_BIT + 1 cycles. This is the minimum inter-frame gap.

## Test plan
- **Reset values.** Assert `i_rst` mid-idle and again mid-DATA -> `o_uart_tx` = 1, `o_tx_busy` = 0, `o_tx_ready` = 0 during reset, ready = 1 after release, no `o_tx_done`.
- **Basic frame.** Defaults (CLKS_PER_BIT = 5208), send 0xAC -> line samples at bit centres = 0, 0,0,1,1,0,1,0,1, 1. `o_tx_done` pulses exactly 10*5208 cycles after the start-bit fall. `o_parity` = 0.
- **Parity.** PARITY_EN = 1, PARITY_ODD = 0, send 0xAC -> parity bit 0, frame 11*5208 cycles. PARITY_ODD = 1, send 0x07 -> parity bit 0. PARITY_ODD = 1, send 0xAC -> parity bit 1.
- **Back-to-back.** Hold `i_tx_valid` with 0x55 then 0xFF -> second start bit begins exactly CLKS_PER_BIT + 1 cycles after the first stop bit starts. Both bytes are correct.
- **Ignored requests.** Change `i_tx_data` to 0x00 and pulse `i_tx_valid` during DATA -> frame still carries 0xAC; no second frame starts.
- **Loopback.** Connect `o_uart_tx` to the receive input of `uart_loop`, send 0xAC -> receiver recovers 0xAC and its parity output matches `o_parity`.
